// File: rtl/pixel_writer.sv
// pixel_writer: queues line-drawer pixels, drops off-screen ones, writes y*H_RES+x; PIXEL_WRITER_CLIP_COUNT_EN adds a clip counter.
// Latency: accept at edge N -> fb_we after N+1; in_ready low only when FIFO full; fb_we/addr/data held until fb_ready.
module pixel_writer #(
  parameter int DEPTH = 4,
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_x,
  input  logic [8:0]  in_y,
  input  logic [2:0]  in_colour,
  output logic [16:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        busy,
  output logic [15:0] clip_count
);

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] colour;
  } pix_t;

  typedef enum logic {IDLE, WRITE} state_e;

  localparam logic [16:0] H_LIM = 17'(H_RES);
  localparam logic [16:0] V_LIM = 17'(V_RES);

  state_e      state_q, state_d;
  logic [16:0] addr_q, addr_d;
  logic [2:0]  data_q, data_d;
  pix_t        in_pix, head;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic        head_vis;
  logic [16:0] head_addr;

  assign in_pix = '{x: in_x, y: in_y, colour: in_colour};
  // resetN gating keeps in_ready low while held in reset
  assign in_ready = resetN & ~fifo_full;
  assign push     = in_valid & in_ready;

  pixel_writer_fifo #(
    .W     ($bits(pix_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetN (resetN),
    .push   (push),
    .pop    (pop),
    .wdata  (in_pix),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head_vis  = ({8'd0, head.x} < H_LIM) && ({8'd0, head.y} < V_LIM);
  assign head_addr = {8'd0, head.y} * H_LIM + {8'd0, head.x};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: pop = ~fifo_empty;
      WRITE: begin
        pop = ~fifo_empty & fb_ready;
        if (fb_ready && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a clipped head costs one IDLE cycle but never a write
    if (pop) begin
      if (head_vis) begin
        state_d = WRITE;
        addr_d  = head_addr;
        data_d  = head.colour;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign fb_we   = (state_q == WRITE);
  assign fb_addr = addr_q;
  assign fb_data = data_q;
  assign busy    = ~fifo_empty | fb_we;

`ifdef PIXEL_WRITER_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (pop && !head_vis && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) clip_cnt_q <= '0;
    else         clip_cnt_q <= clip_cnt_d;
  end

  assign clip_count = clip_cnt_q;
`else
  assign clip_count = '0;
`endif

endmodule

module pixel_writer_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: queue-based reference model checked every cycle, plus directed literal scenarios.
module tb_pixel_writer;

  localparam int DEPTH = 4;
  localparam int H_RES = 320;
  localparam int V_RES = 240;
`ifdef PIXEL_WRITER_CLIP_COUNT_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic        clock;
  logic        resetN;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_x;
  logic [8:0]  in_y;
  logic [2:0]  in_colour;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        busy;
  logic [15:0] clip_count;

  pixel_writer #(.DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .busy       (busy),
    .clip_count (clip_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t pixq[$];
  int   sb_addr[$];
  int   sb_data[$];
  bit   exp_we;
  int   exp_addr, exp_data, exp_clip;
  int   s_vld, s_x, s_y, s_c, s_fbr;
  int   cyc;
  int   wlog_addr[$];
  int   wlog_data[$];
  int   wlog_cyc[$];
  int   n_cmp, n_bad, n_acc;

  function automatic bit visible(input int x, input int y);
    return (x < H_RES) && (y < V_RES);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    pixq.delete();
    sb_addr.delete();
    sb_data.delete();
    exp_we   = 1'b0;
    exp_addr = 0;
    exp_data = 0;
    exp_clip = 0;
  endtask

  // One clock edge of the reference: the head leaves when the write stage is free or completing.
  task automatic model_step();
    bit   acc;
    pix_t p;
    acc = (s_vld != 0) && (pixq.size() < DEPTH);
    if (pixq.size() > 0 && (!exp_we || s_fbr != 0)) begin
      p = pixq.pop_front();
      if (visible(p.x, p.y)) begin
        exp_we   = 1'b1;
        exp_addr = p.y * H_RES + p.x;
        exp_data = p.c;
      end else begin
        exp_we = 1'b0;
        if (exp_clip < 65535) exp_clip++;
      end
    end else if (exp_we && s_fbr != 0) begin
      exp_we = 1'b0;
    end
    if (acc) begin
      p.x = s_x; p.y = s_y; p.c = s_c;
      pixq.push_back(p);
      if (visible(s_x, s_y)) begin
        sb_addr.push_back(s_y * H_RES + s_x);
        sb_data.push_back(s_c);
      end
    end
  endtask

  task automatic compare_outputs();
    chk("fb_we", fb_we, exp_we);
    chk("in_ready", in_ready, (resetN && pixq.size() < DEPTH) ? 1 : 0);
    chk("busy", busy, (pixq.size() > 0 || exp_we) ? 1 : 0);
    chk("clip_count", clip_count, CLIP_EN ? exp_clip : 0);
    if (exp_we || !resetN) begin
      chk("fb_addr", fb_addr, exp_addr);
      chk("fb_data", fb_data, exp_data);
    end
    if (resetN && fb_we && fb_ready) begin
      wlog_addr.push_back(int'(fb_addr));
      wlog_data.push_back(int'(fb_data));
      wlog_cyc.push_back(cyc);
      chk("write_expected", sb_addr.size() > 0 ? 1 : 0, 1);
      if (sb_addr.size() > 0) begin
        chk("order_addr", fb_addr, sb_addr.pop_front());
        chk("order_data", fb_data, sb_data.pop_front());
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge clock or negedge clock or negedge resetN);
      if (!resetN)     model_clear();
      else if (clock)  model_step();
      if (!clock) begin
        cyc++;
        compare_outputs();
        s_vld = int'(in_valid);
        s_x   = int'(in_x);
        s_y   = int'(in_y);
        s_c   = int'(in_colour);
        s_fbr = int'(fb_ready);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input int x, input int y, input int c, output bit ok);
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_x      = 9'(x);
    in_y      = 9'(y);
    in_colour = 3'(c);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("offer_accepted", ok, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #3 resetN = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    @(posedge clock);
    #3 resetN = 1'b1;
    #1;
  endtask

  int bx[6] = '{0, 7, 14, 21, 28, 35};
  int by[6] = '{3, 4, 5, 6, 7, 8};
  int ba[6] = '{960, 1287, 1614, 1941, 2268, 2595};

  initial begin
    bit ok;
    int lb;
    resetN = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0; fb_ready = 1'b0;
    n_cmp = 0; n_bad = 0; n_acc = 0; cyc = 0;
    s_vld = 0; s_x = 0; s_y = 0; s_c = 0; s_fbr = 0;
    model_clear();
    fork
      monitor();
    join_none

    // reset state
    #12;
    chk("reset_fb_we", fb_we, 0);
    chk("reset_fb_addr", fb_addr, 0);
    chk("reset_fb_data", fb_data, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_clip", clip_count, 0);
    #10 resetN = 1'b1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    tick();

    // single pixel
    fb_ready = 1'b1;
    lb = wlog_addr.size();
    offer(5, 2, 3, ok);
    chk("single_we_edge1", fb_we, 0);
    tick();
    chk("single_we_edge2", fb_we, 1);
    chk("single_addr", fb_addr, 645);
    chk("single_data", fb_data, 3);
    tick();
    chk("single_we_done", fb_we, 0);
    chk("single_count", wlog_addr.size() - lb, 1);

    // held handshake + burst with backpressure
    fb_ready = 1'b0;
    lb = wlog_addr.size();
    offer(10, 1, 5, ok);
    tick();
    chk("hold_enter_we", fb_we, 1);
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          offer(bx[i], by[i], i, ok);
          if (ok) n_acc++;
        end
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clock);
          chk("hold_we", fb_we, 1);
          chk("hold_addr", fb_addr, 330);
          chk("hold_data", fb_data, 5);
        end
        chk("burst_accepted_while_stalled", n_acc, 4);
        chk("burst_in_ready_low", in_ready, 0);
        @(posedge clock);
        #1 fb_ready = 1'b1;
      end
    join
    repeat (8) tick();
    chk("burst_write_count", wlog_addr.size() - lb, 7);
    if (wlog_addr.size() - lb == 7) begin
      chk("burst_first_addr", wlog_addr[lb], 330);
      for (int i = 0; i < 6; i++) begin
        chk("burst_addr", wlog_addr[lb + 1 + i], ba[i]);
        chk("burst_data", wlog_data[lb + 1 + i], i);
        chk("burst_back_to_back", wlog_cyc[lb + 1 + i] - wlog_cyc[lb + i], 1);
      end
    end

    // clipping
    pulse_reset();
    fb_ready = 1'b1;
    lb = wlog_addr.size();
    offer(320, 0, 1, ok);
    offer(0, 240, 2, ok);
    offer(319, 239, 6, ok);
    repeat (6) tick();
    chk("clip_write_count", wlog_addr.size() - lb, 1);
    if (wlog_addr.size() - lb == 1) begin
      chk("clip_addr", wlog_addr[lb], 76799);
      chk("clip_data", wlog_data[lb], 6);
    end
    chk("clip_count_value", clip_count, CLIP_EN ? 2 : 0);

    // reset mid-write
    fb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) offer(i, i, i, ok);
    tick();
    chk("midrst_we_before", fb_we, 1);
    chk("midrst_busy_before", busy, 1);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_we", fb_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", fb_addr, 0);
    chk("midrst_data", fb_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clock);
    #3 resetN = 1'b1;
    fb_ready = 1'b1;
    lb = wlog_addr.size();
    repeat (10) tick();
    chk("midrst_no_writes", wlog_addr.size() - lb, 0);
    chk("midrst_in_ready_after", in_ready, 1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = 9'($urandom_range(0, 340));
      in_y      = 9'($urandom_range(0, 260));
      in_colour = 3'($urandom_range(0, 7));
      fb_ready  = (k % 200 < 20) ? 1'b0 : ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    fb_ready = 1'b1;
    for (int k = 0; k < 100 && busy; k++) tick();
    tick();
    chk("drain_idle", busy, 0);
    chk("drain_scoreboard_empty", sb_addr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the pixel FIFO depth in entries (power of two, minimum 2).
REQ-002 The module SHALL have parameter H_RES, default 320, giving the visible width in pixels.
REQ-003 The module SHALL have parameter V_RES, default 240, giving the visible height in pixels.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The module SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the producer offers a pixel.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the FIFO can accept a pixel.
REQ-008 The module SHALL have ports in_x and in_y, input, 9 bits each: the pixel coordinates from the line-drawing datapath.
REQ-009 The module SHALL have port in_colour, input, 3 bits: the pixel colour.
REQ-010 The module SHALL have port fb_addr, output, 17 bits: the framebuffer word address.
REQ-011 The module SHALL have port fb_data, output, 3 bits: the framebuffer write data.
REQ-012 The module SHALL have port fb_we, output, 1 bit: the framebuffer write request.
REQ-013 The module SHALL have port fb_ready, input, 1 bit: the framebuffer accepts the current write.
REQ-014 The module SHALL have port busy, output, 1 bit: work is pending.
REQ-015 The module SHALL have port clip_count, output, 16 bits: the number of discarded off-screen pixels.

Function
REQ-016 A pixel SHALL be accepted on a rising edge where in_valid and in_ready are both 1; {in_x, in_y, in_colour} is pushed into the FIFO.
REQ-017 in_ready SHALL equal 1 exactly when the FIFO holds fewer than DEPTH entries; it is derived from registered occupancy only and never combinationally from fb_ready.
REQ-018 A push and a pop on the same edge SHALL leave occupancy unchanged; no push is possible when the FIFO is full.
REQ-019 The FSM SHALL have two states:
- IDLE: fb_we=0.
- WRITE: fb_we=1.
REQ-020 IDLE with the FIFO non-empty SHALL pop the head entry on the next edge:
- Visible pixel: load fb_addr and fb_data, then go to WRITE.
- Clipped pixel: stay in IDLE.
REQ-021 A pixel SHALL be clipped when in_x >= H_RES or in_y >= V_RES; a clipped pixel produces no fb_we pulse.
REQ-022 fb_addr SHALL equal y*H_RES + x, computed at full 17-bit width with no truncation; for the defaults the maximum is 76799.
REQ-023 WRITE SHALL hold fb_we, fb_addr and fb_data stable until an edge where fb_ready=1. On that edge:
- FIFO non-empty: pop the next entry, handled as in REQ-020, so the FSM goes to WRITE or IDLE.
- FIFO empty: go to IDLE.
REQ-024 Sustained throughput SHALL be one write per clock while the FIFO is non-empty and fb_ready=1.
REQ-025 Latency SHALL be fixed: a pixel accepted into an empty, idle block at edge N gives fb_we=1 after edge N+1.
REQ-026 busy SHALL equal (FIFO non-empty) OR (state == WRITE).
REQ-027 Pixels SHALL be written in acceptance order; the block never drops or duplicates a visible pixel.

Reset
REQ-028 resetN=0 SHALL immediately, without waiting for a clock edge:
- empty the FIFO;
- force IDLE;
- drive fb_we=0, fb_addr=0, fb_data=0 and clip_count=0.
REQ-029 During reset in_ready SHALL be 0 and busy SHALL be 0; after resetN rises, in_ready SHALL be 1.
REQ-030 Reset asserted mid-write SHALL abandon the pending write and all buffered pixels, with no fb_we after release until a new pixel is accepted.

Configuration
REQ-031 When PIXEL_WRITER_CLIP_COUNT_EN is defined, clip_count SHALL increment by 1 per clipped pixel popped and saturate at 65535.
REQ-032 When PIXEL_WRITER_CLIP_COUNT_EN is undefined, clip_count SHALL be tied to 0 and no counter logic is built; clipping itself is unchanged.

Verification
REQ-033 The bench SHALL cover a single pixel: (x=5, y=2, colour=3) with fb_ready=1 -> one fb_we pulse with fb_addr=645, fb_data=3, two edges after acceptance.
REQ-034 The bench SHALL cover a burst with backpressure: 6 pixels offered back-to-back with fb_ready=0 -> in_ready drops to 0 after 4 accepted; with fb_ready=1 all 6 are written in order, one per clock.
REQ-035 The bench SHALL cover clipping: pixels (320,0), (0,240), (319,239) -> only address 76799 is written; clip_count=2 with the macro defined, 0 without.
REQ-036 The bench SHALL cover reset mid-write: resetN pulsed low while fb_we=1 and 3 pixels are queued -> fb_we drops asynchronously, busy=0, no further writes.
REQ-037 The bench SHALL cover a held handshake: fb_ready held 0 for 10 cycles in WRITE -> fb_we, fb_addr and fb_data remain constant throughout.
